// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the set-associative cache.
// Pure declarations: no logic, no latency, no flow control.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } state_e;

  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int sets);
    return addr_w - ofs_w(data_w) - idx_w(sets);
  endfunction

  // A direct-mapped build still needs a 1-bit way index to keep vectors legal.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic bit ways_legal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set tag/data/valid storage with a combinational tag compare.
// Latency: lookup is combinational; writes and clears land on the next edge.
// Backpressure: none, the controller owns all sequencing.
module cache_way #(
  parameter int SETS   = 32,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              hit,
  output logic              vld,
  output logic [DATA_W-1:0] rd_dat
);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= wr_dat;
    end
  end

  assign vld    = valid_q[idx];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_dat = data_q[idx];

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-through, no-write-allocate cache; stats ports under CACHE_STATS_EN.
// Latency: read hit 2 cycles handshake->resp_valid; misses and writes wait on memory.
// Backpressure: req_ready only in IDLE without flush; mem request held stable until mem_req_ready.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFS_W = ofs_w(DATA_W);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, DATA_W, SETS);
  localparam int WAY_W = way_w(WAYS);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("assoc_cache: WAYS must be 1, 2 or 4");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              vic_ptr_q, vic_ptr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [ADDR_W-1:0] lk_addr;
  logic              flush_clr;
  logic [WAYS-1:0]   way_hit, way_vld, way_we;
  logic [DATA_W-1:0] way_rdata [WAYS];
  logic [DATA_W-1:0] way_wdata;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] hit_data;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  cur_ptr;
  logic              ptr_adv;

  assign lk_idx    = addr_q[OFS_W +: IDX_W];
  assign lk_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign lk_addr   = addr_q & ~OFS_MASK;
  assign flush_clr = (state_q == IDLE) && flush;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_way (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush_clr),
      .wr_en (way_we[w]),
      .idx   (lk_idx),
      .tag   (lk_tag),
      .wr_dat(way_wdata),
      .hit   (way_hit[w]),
      .vld   (way_vld[w]),
      .rd_dat(way_rdata[w])
    );
  end

  // Descending scans leave the lowest-index match/invalid way as the winner.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_data  = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(i);
        hit_data = way_rdata[i];
      end
      if (!way_vld[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
  end

  if (WAYS > 1) begin : g_ptr
    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] ptr_d [SETS];

    assign cur_ptr = ptr_q[lk_idx];

    always_comb begin
      ptr_d = ptr_q;
      if (flush_clr) begin
        for (int s = 0; s < SETS; s++) ptr_d[s] = '0;
      end else if (ptr_adv) begin
        ptr_d[lk_idx] = (cur_ptr == WAY_W'(WAYS - 1)) ? '0 : cur_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_no_ptr
    assign cur_ptr = '0;
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    victim_d        = victim_q;
    vic_ptr_d       = vic_ptr_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    way_we          = '0;
    way_wdata       = wdata_q;
    ptr_adv         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          way_we[hit_way] = hit;
          mem_req_valid_d = 1'b1;
          mem_we_d        = 1'b1;
          mem_addr_d      = lk_addr;
          mem_wdata_d     = wdata_q;
          state_d         = WR_REQ;
        end else if (hit) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = hit_data;
          state_d      = IDLE;
        end else begin
          victim_d        = inv_found ? inv_way : cur_ptr;
          vic_ptr_d       = !inv_found;
          mem_req_valid_d = 1'b1;
          mem_we_d        = 1'b0;
          mem_addr_d      = lk_addr;
          state_d         = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          way_we[victim_q] = 1'b1;
          way_wdata        = mem_rdata;
          ptr_adv          = vic_ptr_q;
          resp_valid_d     = 1'b1;
          resp_rdata_d     = mem_rdata;
          state_d          = IDLE;
        end
      end
      WR_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      victim_q        <= '0;
      vic_ptr_q       <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      victim_q        <= victim_d;
      vic_ptr_q       <= vic_ptr_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign req_ready     = (state_q == IDLE) && !flush;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
